seven_segment_scanner: RTL and testbench
========================================

Name: seven_segment_scanner

Overview:
Parametrised, time-multiplexed driver for an N-digit common-anode seven-segment display. It replaces per-digit combinational hex decoding with a single shared decoder and a scan counter that cycles through the digits. Adds tear-free frame-synchronous value updates, per-digit decimal points, leading-zero blanking, PWM brightness and anti-ghosting dead time. It sits between the core logic (value producer) and the board display pins.

Parameters:
NUM_DIGITS, 4, number of digits scanned (>=1)
SCAN_DIV, 50000, clock cycles per digit slot (>=2)
BRIGHT_BITS, 4, width of brightness control

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high reset
load  in  1  single-cycle strobe: capture value/dp_in into pending register
value  in  4*NUM_DIGITS  hex nibbles; digit k = value[4k+3:4k], digit 0 rightmost
dp_in  in  NUM_DIGITS  decimal point request per digit, 1 = lit
blank_en  in  1  1 = suppress leading zeros
brightness  in  BRIGHT_BITS  duty control, all-ones = maximum
seg_n  out  7  active-low segments, bit order {g,f,e,d,c,b,a}
dp_n  out  1  active-low decimal point
an_n  out  NUM_DIGITS  active-low digit enables, one-hot-low or all high
frame_done  out  1  one-cycle pulse when the last digit slot completes

Behaviour:
- Reset (async assert, sync release): seg_n=7'h7F, dp_n=1, an_n=all 1, frame_done=0; scan_cnt=0, digit_idx=0, pending and display registers=0, pending_valid=0.
- Scan: scan_cnt counts 0..SCAN_DIV-1, then wraps to 0 and digit_idx advances; digit_idx wraps NUM_DIGITS-1 -> 0.
- frame_done=1 for exactly the cycle after scan_cnt=SCAN_DIV-1 and digit_idx=NUM_DIGITS-1 (registered).
- Value update: load writes pending <= {value, dp_in} and sets pending_valid; the last load in a frame wins. At the frame boundary (the cycle scan_cnt=SCAN_DIV-1 and digit_idx=NUM_DIGITS-1), the display register is updated. If load is asserted in that same cycle, the display register takes value/dp_in directly. Otherwise, if pending_valid is set, it takes the pending register. pending_valid clears in both cases. The display register never changes mid-frame.
- Decode, active-low: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0011000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- Leading-zero blanking (blank_en=1): digit k is blanked iff its nibble and every nibble above k are 0, for k >= 1. Digit 0 is never blanked. Blanked digit: seg_n=7'h7F, but its anode still follows the PWM rule and dp_n still follows dp. blank_en is sampled combinationally each cycle.
- Brightness: on_limit = ((brightness+1)*SCAN_DIV) >> BRIGHT_BITS, computed at full width without overflow.
- Anode enable: an_n[digit_idx]=0 iff 1 <= scan_cnt < on_limit; all other anodes are 1.
- scan_cnt=0 is mandatory dead time: all anodes off, preventing ghosting. If on_limit <= 1, the digit stays dark.
- brightness is sampled at scan_cnt=0 of each slot and held for the whole slot.
- Latency: seg_n, dp_n and an_n are registered. Outputs in cycle t+1 reflect scan_cnt, digit_idx and display state of cycle t. seg_n/dp_n update for the new digit in the same cycle its dead time appears on an_n.
- Reset mid-scan: all outputs go immediately to reset values; the scan restarts at digit 0, slot count 0. Any pending load is discarded.
- NUM_DIGITS=1: digit_idx is constant 0 and frame_done pulses every SCAN_DIV cycles.

Test Plan:
(Bench parameters for all: NUM_DIGITS=4, SCAN_DIV=8, BRIGHT_BITS=2.)
1. Scan/decode: reset, load value=16'h12AF, dp_in=0, brightness=3, run 2 frames. Second frame: digits 0..3 show seg_n=0001110, 0001000, 0100100, 1111001. an_n per slot: 1111 for 1 cycle, then 1110 (0111-order per digit) for 7 cycles. frame_done every 32 cycles.
2. Tear-free update: load 16'h1111 at frame start, load 16'h2222 mid-frame. No change for the rest of the frame; next frame shows 2 on all digits, never 1. Load at the boundary cycle is shown in the next frame.
3. Blanking: value=16'h0050, blank_en=1. Digits 3 and 2 show seg_n=7F with anodes still pulsing; digit 1 shows 5, digit 0 shows 0. value=16'h0000 shows only digit 0 as 1000000.
4. Brightness: brightness=0 gives on_limit=2, anode low 1 cycle per slot. brightness=1 gives 3 cycles. Changing brightness mid-slot has no effect until the next slot.
5. Decimal point: dp_in=4'b0100 with blank_en=1 and value=0. dp_n=0 only during digit 2 slot enables, even though digit 2 is blanked.
6. Reset mid-slot (scan_cnt=5, digit 2, pending load): seg_n=7F, an_n=1111 immediately. After release, scan restarts at digit 0 and the display shows 0s.

Source files
------------

// File: rtl/seven_segment_scanner_if.sv
`default_nettype none
// ============================================================================
// Module   : seven_segment_scanner_if
// Purpose  : Bundles the value-producer inputs and the display-pin outputs of
//            the seven-segment scanner. The producer side uses "master" and
//            the scanner uses "slave".
// Revision : 1.0 - initial release
// ============================================================================
interface seven_segment_scanner_if #(
  parameter int NUM_DIGITS  = 4,
  parameter int BRIGHT_BITS = 4
);
  // Producer side: value update and display controls
  logic                    load;
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic                    blank_en;
  logic [BRIGHT_BITS-1:0]  brightness;

  // Display side: active-low pins and the frame marker
  logic [6:0]              seg_n;
  logic                    dp_n;
  logic [NUM_DIGITS-1:0]   an_n;
  logic                    frame_done;

  modport master (
    output load, value, dp_in, blank_en, brightness,
    input  seg_n, dp_n, an_n, frame_done
  );

  modport slave (
    input  load, value, dp_in, blank_en, brightness,
    output seg_n, dp_n, an_n, frame_done
  );
endinterface
`default_nettype wire

// File: rtl/seven_segment_scanner.sv
`default_nettype none
// ============================================================================
// Module   : seven_segment_scanner
// Purpose  : Time-multiplexed driver for an N-digit common-anode seven-segment
//            display. One shared hex decoder and a scan counter walk the
//            digits. Value updates take effect only at frame boundaries. The
//            driver also provides per-digit decimal points, leading-zero
//            blanking, PWM brightness and a one-cycle anti-ghosting dead time
//            at the start of each digit slot.
// Revision : 1.0 - initial release
// ============================================================================
module seven_segment_scanner #(
  parameter int NUM_DIGITS  = 4,
  parameter int SCAN_DIV    = 50000,
  parameter int BRIGHT_BITS = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  seven_segment_scanner_if.slave   bus
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  // (brightness+1) <= 2^BRIGHT_BITS and SCAN_DIV < 2^clog2(SCAN_DIV+1), so the
  // product always fits; one spare bit keeps the arithmetic obviously safe.
  localparam int LIM_W = BRIGHT_BITS + 1 + $clog2(SCAN_DIV + 1);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  // Scan position
  logic [CNT_W-1:0]          scan_cnt;
  logic [IDX_W-1:0]          digit_idx;
  logic                      slot_end;
  logic                      frame_end;

  // Pending (producer-facing) and display (frame-stable) registers
  logic [4*NUM_DIGITS-1:0]   pend_value;
  logic [NUM_DIGITS-1:0]     pend_dp;
  logic                      pend_valid;
  logic [4*NUM_DIGITS-1:0]   disp_value;
  logic [NUM_DIGITS-1:0]     disp_dp;

  // Brightness captured at the dead-time cycle of each slot
  logic [BRIGHT_BITS-1:0]    bright_hold;
  logic [LIM_W-1:0]          on_product;
  logic [LIM_W-1:0]          on_limit;
  logic                      anode_on;

  // Current-digit selection and blanking
  logic [NUM_DIGITS-1:0]     zero_from;
  logic                      zero_run;
  logic [3:0]                cur_nib;
  logic                      cur_dp;
  logic                      cur_zero;
  logic                      cur_blank;
  logic [NUM_DIGITS-1:0]     an_next;

  // Registered outputs
  logic [6:0]                seg_n_q;
  logic                      dp_n_q;
  logic [NUM_DIGITS-1:0]     an_n_q;
  logic                      frame_done_q;

  // Shared hex-to-segment decoder, active-low, bit order {g,f,e,d,c,b,a}
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0011000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

  assign slot_end  = (scan_cnt == LAST_CNT);
  assign frame_end = slot_end && (digit_idx == LAST_IDX);

  // Scan counter: slot cycle count, then advance to the next digit and wrap
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_cnt  <= '0;
      digit_idx <= '0;
    end else if (slot_end) begin
      scan_cnt  <= '0;
      digit_idx <= (digit_idx == LAST_IDX) ? '0 : digit_idx + IDX_W'(1);
    end else begin
      scan_cnt  <= scan_cnt + CNT_W'(1);
    end
  end

  // Value staging: loads collect in pending and are copied to the display only
  // at the frame boundary, so a frame is never drawn with mixed values. A load
  // that lands exactly on the boundary bypasses pending and shows next frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_value <= '0;
      pend_dp    <= '0;
      pend_valid <= 1'b0;
      disp_value <= '0;
      disp_dp    <= '0;
    end else if (frame_end) begin
      if (bus.load) begin
        disp_value <= bus.value;
        disp_dp    <= bus.dp_in;
      end else if (pend_valid) begin
        disp_value <= pend_value;
        disp_dp    <= pend_dp;
      end
      pend_valid <= 1'b0;
    end else if (bus.load) begin
      pend_value <= bus.value;
      pend_dp    <= bus.dp_in;
      pend_valid <= 1'b1;
    end
  end

  // Brightness is sampled once per slot so a mid-slot change cannot stretch
  // or clip the current digit's on-time.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bright_hold <= '0;
    end else if (scan_cnt == '0) begin
      bright_hold <= bus.brightness;
    end
  end

  assign on_product = (LIM_W'(bright_hold) + LIM_W'(1)) * LIM_W'(SCAN_DIV);
  assign on_limit   = on_product >> BRIGHT_BITS;
  // Cycle 0 of every slot is dead time; lit window is 1 <= scan_cnt < on_limit
  assign anode_on   = (scan_cnt != '0) && (LIM_W'(scan_cnt) < on_limit);

  // Leading-zero run: zero_from[k] is set when digit k and all above are zero
  always_comb begin
    zero_run  = 1'b1;
    zero_from = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_run     = zero_run && (disp_value[4*k +: 4] == 4'h0);
      zero_from[k] = zero_run;
    end
  end

  // Select nibble, decimal point and zero-run flag of the digit being scanned
  always_comb begin
    cur_nib  = 4'h0;
    cur_dp   = 1'b0;
    cur_zero = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (digit_idx == IDX_W'(k)) begin
        cur_nib  = disp_value[4*k +: 4];
        cur_dp   = disp_dp[k];
        cur_zero = zero_from[k];
      end
    end
  end

  // Digit 0 is never blanked so a zero value still shows a single "0"
  assign cur_blank = bus.blank_en && (digit_idx != '0) && cur_zero;

  // One-hot-low anode pattern for the digit being scanned
  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_anode
    assign an_next[k] = !(anode_on && (digit_idx == IDX_W'(k)));
  end

  // Output register: pins reflect the previous cycle's scan state, so the new
  // digit's segments appear together with its dead-time cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg_n_q      <= 7'h7F;
      dp_n_q       <= 1'b1;
      an_n_q       <= '1;
      frame_done_q <= 1'b0;
    end else begin
      seg_n_q      <= cur_blank ? 7'h7F : hex_to_seg(cur_nib);
      dp_n_q       <= !cur_dp;
      an_n_q       <= an_next;
      frame_done_q <= frame_end;
    end
  end

  assign bus.seg_n      = seg_n_q;
  assign bus.dp_n       = dp_n_q;
  assign bus.an_n       = an_n_q;
  assign bus.frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_seven_segment_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_seven_segment_scanner
// Purpose  : Self-checking bench for seven_segment_scanner (4 digits, 8-cycle
//            slots, 2-bit brightness). A cycle-position reference model
//            predicts every output; directed literal checks pin key cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seven_segment_scanner;

  localparam int ND = 4;
  localparam int SD = 8;
  localparam int BB = 2;
  localparam int FRAME = ND * SD;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  seven_segment_scanner_if #(.NUM_DIGITS(ND), .BRIGHT_BITS(BB)) bus ();

  seven_segment_scanner #(
    .NUM_DIGITS (ND),
    .SCAN_DIV   (SD),
    .BRIGHT_BITS(BB)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic fail_timeout(input string name);
    n_checks++;
    $display("FAIL %s: timed out waiting at %0t", name, $time);
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;  4'h9: return 7'b0011000;
      4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  // ---------------- reference model ----------------
  // Scan position is derived from the number of clock edges since reset.
  int          m_cyc;
  logic [15:0] m_disp, m_pend;
  logic [3:0]  m_disp_dp, m_pend_dp;
  bit          m_pv;
  int          m_bright;
  logic [6:0]  exp_seg;
  logic        exp_dp;
  logic [3:0]  exp_an;
  logic        exp_fd;

  task automatic model_step();
    int cnt, dig, lim;
    bit boundary, blank;
    logic [3:0] nib;
    if (reset) begin
      m_cyc = 0; m_disp = '0; m_pend = '0; m_disp_dp = '0; m_pend_dp = '0;
      m_pv = 0; m_bright = 0;
      exp_seg = 7'h7F; exp_dp = 1'b1; exp_an = 4'hF; exp_fd = 1'b0;
      return;
    end
    cnt = m_cyc % SD;
    dig = (m_cyc / SD) % ND;
    boundary = (cnt == SD - 1) && (dig == ND - 1);
    nib   = 4'((m_disp >> (4 * dig)) & 16'hF);
    blank = bus.blank_en && (dig >= 1) && ((m_disp >> (4 * dig)) == 16'h0);
    exp_seg = blank ? 7'h7F : seg_of(nib);
    exp_dp  = !m_disp_dp[dig];
    lim = ((m_bright + 1) * SD) >> BB;
    exp_an = 4'hF;
    if (cnt >= 1 && cnt < lim) exp_an[dig] = 1'b0;
    exp_fd = boundary;
    if (cnt == 0) m_bright = int'(bus.brightness);
    if (boundary) begin
      if (bus.load) begin m_disp = bus.value; m_disp_dp = bus.dp_in; end
      else if (m_pv) begin m_disp = m_pend; m_disp_dp = m_pend_dp; end
      m_pv = 0;
    end else if (bus.load) begin
      m_pend = bus.value; m_pend_dp = bus.dp_in; m_pv = 1;
    end
    m_cyc++;
  endtask

  initial forever begin
    @(posedge clk or posedge reset);
    model_step();
  end

  // Compare every output against the model on each falling edge
  initial forever begin
    @(negedge clk);
    check("seg_n", bus.seg_n, exp_seg);
    check("dp_n", bus.dp_n, exp_dp);
    check("an_n", bus.an_n, exp_an);
    check("frame_done", bus.frame_done, exp_fd);
  end

  // ---------------- stimulus helpers ----------------
  // Caller is positioned just after a rising edge; load lasts one cycle.
  task automatic load_word(input logic [15:0] v, input logic [3:0] d);
    bus.value = v; bus.dp_in = d; bus.load = 1'b1;
    @(posedge clk); #1;
    bus.load = 1'b0;
  endtask

  task automatic wait_fd();
    bit found = 0;
    for (int i = 0; i < 4 * FRAME; i++) begin
      @(negedge clk);
      if (bus.frame_done) begin found = 1; break; end
    end
    if (!found) fail_timeout("frame_done");
  endtask

  task automatic digit_seg(input string name, input logic [3:0] pat, input logic [6:0] exp);
    bit found = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      if (bus.an_n == pat) begin found = 1; break; end
    end
    if (found) check(name, bus.seg_n, exp);
    else fail_timeout(name);
  endtask

  task automatic count_lit(output int lit);
    lit = 0;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      if (bus.an_n != 4'hF) lit++;
    end
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    int n, period, dp_ok, dp_bad, dp_all;
    bus.load = 1'b0; bus.value = '0; bus.dp_in = '0;
    bus.blank_en = 1'b0; bus.brightness = 2'd3;
    repeat (3) @(posedge clk);
    #1;
    check("rst_seg", bus.seg_n, 7'h7F);
    check("rst_an", bus.an_n, 4'hF);
    check("rst_dp", bus.dp_n, 1'b1);
    reset = 1'b0;

    // Scan/decode
    load_word(16'h12AF, 4'h0);
    wait_fd();
    digit_seg("t1_d0", 4'b1110, 7'b0001110);
    digit_seg("t1_d1", 4'b1101, 7'b0001000);
    digit_seg("t1_d2", 4'b1011, 7'b0100100);
    digit_seg("t1_d3", 4'b0111, 7'b1111001);
    wait_fd();
    period = 0;
    for (int i = 0; i < 4 * FRAME; i++) begin
      @(negedge clk); period++;
      if (bus.frame_done) break;
    end
    check("fd_period", period, FRAME);

    // Tear-free update: two loads in one frame, last wins
    @(posedge clk); #1;
    load_word(16'h1111, 4'h0);
    repeat (10) @(posedge clk);
    #1;
    load_word(16'h2222, 4'h0);
    wait_fd();
    digit_seg("t2_d0", 4'b1110, 7'b0100100);
    digit_seg("t2_d3", 4'b0111, 7'b0100100);
    // Load exactly on the boundary cycle
    wait_fd();
    repeat (FRAME - 1) @(posedge clk);
    #1;
    load_word(16'h3333, 4'h0);
    wait_fd();
    digit_seg("t2_bnd", 4'b1110, 7'b0110000);

    // Leading-zero blanking
    bus.blank_en = 1'b1;
    @(posedge clk); #1;
    load_word(16'h0050, 4'h0);
    wait_fd();
    digit_seg("t3_d0", 4'b1110, 7'b1000000);
    digit_seg("t3_d1", 4'b1101, 7'b0010010);
    digit_seg("t3_d2", 4'b1011, 7'h7F);
    digit_seg("t3_d3", 4'b0111, 7'h7F);
    @(posedge clk); #1;
    load_word(16'h0000, 4'h0);
    wait_fd();
    digit_seg("t3z_d0", 4'b1110, 7'b1000000);
    digit_seg("t3z_d1", 4'b1101, 7'h7F);

    // Brightness
    bus.brightness = 2'd0;
    wait_fd(); wait_fd();
    count_lit(n);
    check("bright0_lit", n, 4);
    bus.brightness = 2'd1;
    wait_fd(); wait_fd();
    count_lit(n);
    check("bright1_lit", n, 12);
    bus.brightness = 2'd3;

    // Decimal point on a blanked digit
    @(posedge clk); #1;
    load_word(16'h0000, 4'b0100);
    wait_fd(); wait_fd();
    dp_ok = 0; dp_bad = 0; dp_all = 0;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      if (!bus.dp_n) begin
        dp_all++;
        if (bus.an_n == 4'b1011) dp_ok++;
        else if (bus.an_n != 4'hF) dp_bad++;
      end
    end
    check("dp_lit", dp_ok, 7);
    check("dp_wrong_digit", dp_bad, 0);
    check("dp_slot", dp_all, 8);

    // Reset at digit 2, slot count 5, with a load pending
    bus.blank_en = 1'b0;
    wait_fd();
    repeat (5) @(posedge clk);
    #1;
    load_word(16'hABCD, 4'hF);
    repeat (15) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("t6_seg", bus.seg_n, 7'h7F);
    check("t6_an", bus.an_n, 4'hF);
    check("t6_fd", bus.frame_done, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    wait_fd();
    digit_seg("t6_d0", 4'b1110, 7'b1000000);
    digit_seg("t6_d3", 4'b0111, 7'b1000000);

    // Randomised traffic, fully checked by the model
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk); #1;
      bus.value = 16'($urandom);
      bus.dp_in = 4'($urandom);
      bus.load  = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 9) == 0) bus.brightness = 2'($urandom);
      if ($urandom_range(0, 19) == 0) bus.blank_en = ~bus.blank_en;
      if (i == 700) reset = 1'b1;
      if (i == 703) reset = 1'b0;
    end
    @(posedge clk); #1;
    bus.load = 1'b0;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
